// File: rtl/crossbar_arbiter_unit_pkg.sv
// Shared types for the crossbar arbitration logic.
// Each slave-side arbiter is either free to arbitrate or locked to one master.
package crossbar_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/crossbar_arbiter_unit_if.sv
// Handshake and grant bundle between the requesting masters and the crossbar arbiter.
// The arbiter side uses the slave modport; whatever drives the masters uses master.
interface crossbar_arbiter_unit_if #(
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3
);
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT);
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT);

    logic [S_DATA_COUNT-1:0][T_DEST_WIDTH-1:0] s_dest_i;
    logic [S_DATA_COUNT-1:0]                   s_last_i;
    logic [S_DATA_COUNT-1:0]                   s_valid_i;
    logic [M_DATA_COUNT-1:0]                   m_ready_i;
    logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_o;
    logic [M_DATA_COUNT-1:0]                   grant_valid_o;

    modport slave (
        input  s_dest_i, s_last_i, s_valid_i, m_ready_i,
        output grant_o, grant_valid_o
    );

    modport master (
        output s_dest_i, s_last_i, s_valid_i, m_ready_i,
        input  grant_o, grant_valid_o
    );

endinterface

// File: rtl/crossbar_arbiter_unit_rr_arbiter.sv
// Round-robin arbiter for one slave: grants a master and holds it until the
// owner's last beat is accepted.
//   state      | meaning
//   ARB_IDLE   | no owner; pick a winner from req on the next edge
//   ARB_LOCKED | grant held for the owner until its last-beat handshake
module rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [N-1:0]   req,
    input  logic           last_hs,
    output logic [IDW-1:0] grant,
    output logic           grant_valid
);

    arb_state_e     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] idx;
    logic           found;

    // search starts just after the previous owner, so it gets lowest priority
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= IDW'(N - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        grant       <= winner;
                        grant_valid <= 1'b1;
                        state       <= ARB_LOCKED;
                    end else begin
                        grant_valid <= 1'b0;
                    end
                end
                ARB_LOCKED: begin
                    if (last_hs) begin
                        grant_valid <= 1'b0;
                        ptr         <= grant;
                        state       <= ARB_IDLE;
                    end
                end
                default: begin
                    grant_valid <= 1'b0;
                    state       <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/crossbar_arbiter_unit.sv
// Crossbar arbitration: one independent round-robin arbiter per slave stream,
// each fed by the masters currently addressing that slave.
module crossbar_arbiter_unit #(
    parameter int S_DATA_COUNT = 2,
    parameter int M_DATA_COUNT = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    crossbar_arbiter_unit_if.slave  bus
);

    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT);
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT);

    logic [M_DATA_COUNT-1:0][T_ID___WIDTH-1:0] grant_all;
    logic [M_DATA_COUNT-1:0]                   grant_valid_all;

    for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_slave
        logic [S_DATA_COUNT-1:0] req;
        logic                    last_hs;

        always_comb begin
            req = '0;
            for (int s = 0; s < S_DATA_COUNT; s++) begin
                req[s] = bus.s_valid_i[s] && (bus.s_dest_i[s] == T_DEST_WIDTH'(m));
            end
        end

        // release only on the owner's last beat, addressed here, accepted by this slave
        assign last_hs = req[grant_all[m]] && bus.s_last_i[grant_all[m]] && bus.m_ready_i[m];

        rr_arbiter #(
            .N   (S_DATA_COUNT),
            .IDW (T_ID___WIDTH)
        ) u_arb (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .req         (req),
            .last_hs     (last_hs),
            .grant       (grant_all[m]),
            .grant_valid (grant_valid_all[m])
        );
    end

    assign bus.grant_o       = grant_all;
    assign bus.grant_valid_o = grant_valid_all;

endmodule

// File: doc/crossbar_arbiter_unit.md
CROSSBAR_ARBITER_UNIT -- requirements
Module: crossbar_arbiter_unit

Interface
REQ-001 Parameter S_DATA_COUNT, default 2: number of input (master) streams, SHALL be >= 2.
REQ-002 Parameter M_DATA_COUNT, default 3: number of output (slave) streams, SHALL be >= 2.
REQ-003 Localparams T_ID___WIDTH = $clog2(S_DATA_COUNT) and T_DEST_WIDTH = $clog2(M_DATA_COUNT) SHALL size IDs and destinations.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 s_dest_i  input  [T_DEST_WIDTH-1:0] x S_DATA_COUNT  destination of each master's current beat.
REQ-007 s_last_i  input  [S_DATA_COUNT-1:0]  last-beat flag per master.
REQ-008 s_valid_i  input  [S_DATA_COUNT-1:0]  valid per master.
REQ-009 m_ready_i  input  [M_DATA_COUNT-1:0]  ready per slave.
REQ-010 grant_o  output  [T_ID___WIDTH-1:0] x M_DATA_COUNT  master index owning each slave; drives the data communication net's grant input.
REQ-011 grant_valid_o  output  [M_DATA_COUNT-1:0]  slave is locked to grant_o; crossbar top SHALL AND it into m_valid_o.

Function
REQ-012 Per slave m, request vector req_m[s] SHALL be s_valid_i[s] && (s_dest_i[s] == m).
REQ-013 Each slave SHALL run an independent two-state FSM: ARB_IDLE, ARB_LOCKED.
REQ-014 ARB_IDLE with req_m nonzero: SHALL select winner by round-robin (search from ptr_m+1 upward, wrap at S_DATA_COUNT-1 to 0), register grant_o[m]=winner, grant_valid_o[m]=1, go ARB_LOCKED; latency one cycle from request to grant.
REQ-015 ARB_IDLE with req_m zero: SHALL stay idle, grant_valid_o[m]=0, grant_o[m] holds its previous value.
REQ-016 ARB_LOCKED: grant_o[m] SHALL be held unchanged regardless of other requests.
REQ-017 ARB_LOCKED exits when s_valid_i[g] && s_dest_i[g]==m && s_last_i[g] && m_ready_i[m] (g = grant_o[m]); next cycle SHALL be ARB_IDLE, grant_valid_o[m]=0, ptr_m=g.
REQ-018 Non-last handshakes, owner valid deasserted, or owner dest temporarily changed SHALL NOT release the lock.
REQ-019 Last handshake with competing requests pending: one idle cycle SHALL follow before re-arbitration (one bubble per packet, by design).
REQ-020 Different slaves SHALL arbitrate and lock concurrently and independently; one master may own only one slave at a time by virtue of a single s_dest_i.
REQ-021 ptr_m SHALL update only on lock release, never on grant.
REQ-022 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-023 Reset SHALL set every FSM to ARB_IDLE, grant_o all 0, grant_valid_o all 0, ptr_m = S_DATA_COUNT-1 (master 0 highest first priority).
REQ-024 Reset asserted mid-packet SHALL drop all locks immediately (asynchronously); no partial state survives deassertion.

Structure
REQ-025 Shared package crossbar_pkg SHALL hold typedef enum arb_state_e {ARB_IDLE, ARB_LOCKED}.
REQ-026 Per-slave logic SHALL be one sub-module rr_arbiter (request vector, last-handshake strobe in; grant, grant_valid out), instantiated M_DATA_COUNT times by generate.
REQ-027 Widths SHALL derive only from the parameters; no hard-coded master/slave counts.

Verification (S_DATA_COUNT=2, M_DATA_COUNT=3)
REQ-028 Reset: rst_ni=0 -> grant_valid_o=3'b000, all grant_o=0; release, no requests -> stays 0.
REQ-029 Master 0, dest=1, 3-beat packet, m_ready_i=3'b111 -> grant_o[1]=0, grant_valid_o[1]=1 one cycle after first valid; grant_valid_o[1]=0 the cycle after beat 3 handshake.
REQ-030 Masters 0 and 1 both dest=2 same cycle -> master 0 granted first; after its last, one idle cycle, master 1 granted; repeat contention -> master 0 granted again.
REQ-031 Master 1 locked on slave 0, m_ready_i[0]=0 with s_last_i[1]=1 for 10 cycles -> lock and grant_o[0]=1 held all 10 cycles; release one cycle after ready rises.
REQ-032 Master 0 dest=0 and master 1 dest=2 same cycle -> grant_valid_o=3'b101, grant_o[0]=0, grant_o[2]=1 in the same cycle.
REQ-033 rst_ni pulsed low while slave 1 locked mid-packet -> grant_valid_o[1]=0 without waiting for a clock edge; after release, arbitration restarts from master 0 priority.
